sd_linebuf_arbiter: RTL

SD_LINEBUF_ARBITER -- requirements
Module: sd_linebuf_arbiter

---
 rtl/sd_linebuf_arbiter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/sd_linebuf_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sd_linebuf_arbiter
//  Brief    : Shares one single-port line-buffer RAM between an input-rate
//             pixel writer and an output-rate pixel reader. Reads always win;
//             writes wait in a 2-entry FIFO and are forwarded to reads that
//             hit a still-pending entry.
//  Revision : 1.0 - initial release
// ============================================================================
module sd_linebuf_arbiter #(
    parameter int HCNT_WIDTH = 9,
    parameter int DW         = 18
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  pe_in,
    input  logic [HCNT_WIDTH-1:0] hcnt_in,
    input  logic                  line_in,
    input  logic [DW-1:0]         din,
    input  logic                  pe_out,
    input  logic [HCNT_WIDTH-1:0] hcnt_out,
    output logic [HCNT_WIDTH:0]   ram_addr,
    output logic                  ram_we,
    output logic [DW-1:0]         ram_wdata,
    input  logic [DW-1:0]         ram_rdata,
    output logic                  rd_valid,
    output logic [DW-1:0]         rd_data,
    output logic [1:0]            fifo_level,
    input  logic                  clr_overflow,
    output logic                  overflow
);

    localparam int c_AW = HCNT_WIDTH + 1;

    // Write FIFO: entry 0 is always the head, entry 1 the tail when full.
    logic [c_AW-1:0] r_e0_addr;
    logic [DW-1:0]   r_e0_data;
    logic [c_AW-1:0] r_e1_addr;
    logic [DW-1:0]   r_e1_data;
    logic [1:0]      r_level;

    logic [c_AW-1:0] w_e0_addr_nxt;
    logic [DW-1:0]   w_e0_data_nxt;
    logic [c_AW-1:0] w_e1_addr_nxt;
    logic [DW-1:0]   w_e1_data_nxt;
    logic [1:0]      w_level_nxt;

    // Read-return pipeline (address stage, RAM stage) with forward capture.
    logic            r_rd_p1;
    logic            r_rd_p2;
    logic            r_fwd_hit_p1;
    logic            r_fwd_hit_p2;
    logic [DW-1:0]   r_fwd_data_p1;
    logic [DW-1:0]   r_fwd_data_p2;

    logic [c_AW-1:0] w_push_addr;
    logic [c_AW-1:0] w_rd_addr;
    logic            w_pop;
    logic            w_full;
    logic            w_accept;
    logic            w_drop;
    logic            w_fwd_hit;
    logic [DW-1:0]   w_fwd_data;

    // The bank is captured with the entry so a later line toggle cannot
    // redirect a pending write; reads target the bank not being written.
    assign w_push_addr = {line_in, hcnt_in};
    assign w_rd_addr   = {~line_in, hcnt_out};

    // A pop only ever takes an entry that was present before this edge, so a
    // same-cycle push is never written in the cycle it arrives.
    assign w_pop    = ~pe_out & (r_level != 2'd0);
    assign w_full   = (r_level == 2'd2);
    assign w_accept = pe_in & (~w_full | w_pop);
    assign w_drop   = pe_in & w_full & ~w_pop;

    assign fifo_level = r_level;

    // FIFO next state: push appends at the tail, pop shifts tail into head.
    always_comb begin
        w_e0_addr_nxt = r_e0_addr;
        w_e0_data_nxt = r_e0_data;
        w_e1_addr_nxt = r_e1_addr;
        w_e1_data_nxt = r_e1_data;
        w_level_nxt   = r_level;
        case ({w_accept, w_pop})
            2'b10: begin
                if (r_level == 2'd0) begin
                    w_e0_addr_nxt = w_push_addr;
                    w_e0_data_nxt = din;
                end else begin
                    w_e1_addr_nxt = w_push_addr;
                    w_e1_data_nxt = din;
                end
                w_level_nxt = r_level + 2'd1;
            end
            2'b01: begin
                w_e0_addr_nxt = r_e1_addr;
                w_e0_data_nxt = r_e1_data;
                w_level_nxt   = r_level - 2'd1;
            end
            2'b11: begin
                if (r_level == 2'd1) begin
                    w_e0_addr_nxt = w_push_addr;
                    w_e0_data_nxt = din;
                end else begin
                    w_e0_addr_nxt = r_e1_addr;
                    w_e0_data_nxt = r_e1_data;
                    w_e1_addr_nxt = w_push_addr;
                    w_e1_data_nxt = din;
                end
            end
            default: begin
                w_level_nxt = r_level;
            end
        endcase
    end

    // Forward source for a read: newest matching pending write wins.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        if (w_accept && (w_push_addr == w_rd_addr)) begin
            w_fwd_hit  = 1'b1;
            w_fwd_data = din;
        end else if ((r_level == 2'd2) && (r_e1_addr == w_rd_addr)) begin
            w_fwd_hit  = 1'b1;
            w_fwd_data = r_e1_data;
        end else if ((r_level != 2'd0) && (r_e0_addr == w_rd_addr)) begin
            w_fwd_hit  = 1'b1;
            w_fwd_data = r_e0_data;
        end
    end

    // FIFO storage, level and sticky overflow (a drop beats a clear).
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_e0_addr <= '0;
            r_e0_data <= '0;
            r_e1_addr <= '0;
            r_e1_data <= '0;
            r_level   <= 2'd0;
            overflow  <= 1'b0;
        end else begin
            r_e0_addr <= w_e0_addr_nxt;
            r_e0_data <= w_e0_data_nxt;
            r_e1_addr <= w_e1_addr_nxt;
            r_e1_data <= w_e1_data_nxt;
            r_level   <= w_level_nxt;
            if (w_drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    // RAM port: read beats write; idle cycles hold address and data.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
        end else begin
            ram_we <= w_pop;
            if (pe_out) begin
                ram_addr <= w_rd_addr;
            end else if (w_pop) begin
                ram_addr  <= r_e0_addr;
                ram_wdata <= r_e0_data;
            end
        end
    end

    // Read-return pipeline: RAM data lands two edges after the request.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_p1       <= 1'b0;
            r_rd_p2       <= 1'b0;
            r_fwd_hit_p1  <= 1'b0;
            r_fwd_hit_p2  <= 1'b0;
            r_fwd_data_p1 <= '0;
            r_fwd_data_p2 <= '0;
            rd_valid      <= 1'b0;
            rd_data       <= '0;
        end else begin
            r_rd_p1       <= pe_out;
            r_fwd_hit_p1  <= pe_out & w_fwd_hit;
            r_fwd_data_p1 <= w_fwd_data;
            r_rd_p2       <= r_rd_p1;
            r_fwd_hit_p2  <= r_fwd_hit_p1;
            r_fwd_data_p2 <= r_fwd_data_p1;
            rd_valid      <= r_rd_p2;
            if (r_rd_p2) begin
                rd_data <= r_fwd_hit_p2 ? r_fwd_data_p2 : ram_rdata;
            end
        end
    end

endmodule
`default_nettype wire
